// File: rtl/potential_updater_pkg.sv
// Shared definitions for the neuron potential updater: FSM encoding, default
// neuron constants and the saturating adder used by the LIF datapath.
package potential_updater_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        CALC,
        WR_REQ
    } state_e;

    localparam int DEFAULT_THRESH  = 1000;
    localparam int DEFAULT_V_RESET = 0;
    localparam logic [7:0] STALL_MAX = 8'd255;

    // Operands arrive sign-extended to 64 bits, so for width <= 63 the raw sum
    // cannot overflow and can be clamped to the signed range of 'width' bits.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 width
    );
        logic signed [63:0] sum;
        logic signed [63:0] maxV;
        logic signed [63:0] minV;
        sum  = a + b;
        maxV = (64'sd1 <<< (width - 1)) - 64'sd1;
        minV = -maxV - 64'sd1;
        if (sum > maxV) begin
            return maxV;
        end
        if (sum < minV) begin
            return minV;
        end
        return sum;
    endfunction

endpackage

// File: rtl/potential_updater_lif.sv
// Combinational LIF step: saturating potential + weight, threshold compare,
// and selection of the value to write back.
module lif_calc
    import potential_updater_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int THRESH  = DEFAULT_THRESH,
    parameter int V_RESET = DEFAULT_V_RESET
) (
    input  logic signed [WIDTH-1:0] pot_i,
    input  logic signed [WIDTH-1:0] weight_i,
    output logic                    fire_o,
    output logic signed [WIDTH-1:0] wr_data_o
);

    localparam logic signed [63:0]      THRESH_L  = 64'(THRESH);
    localparam logic signed [WIDTH-1:0] V_RESET_W = WIDTH'(V_RESET);

    logic signed [63:0] wideSum;

    // The compare is done in 64-bit space; the saturated sum always fits WIDTH.
    always_comb begin
        wideSum   = sat_add({{(64-WIDTH){pot_i[WIDTH-1]}}, pot_i},
                            {{(64-WIDTH){weight_i[WIDTH-1]}}, weight_i},
                            WIDTH);
        fire_o    = (wideSum >= THRESH_L);
        wr_data_o = fire_o ? V_RESET_W : wideSum[WIDTH-1:0];
    end

endmodule

// File: rtl/potential_updater.sv
// Read-modify-write client that applies one synaptic event at a time to a
// shared neuron potential memory through arbitrated read and write ports.
module potential_updater
    import potential_updater_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 16,
    parameter int THRESH  = DEFAULT_THRESH,
    parameter int V_RESET = DEFAULT_V_RESET
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ev_valid,
    output logic                        ev_ready,
    input  logic [$clog2(DEPTH)-1:0]    ev_addr,
    input  logic signed [WIDTH-1:0]     ev_weight,
    output logic                        rd_req,
    input  logic                        rd_grant,
    output logic [$clog2(DEPTH)-1:0]    rd_addr,
    input  logic signed [WIDTH-1:0]     rd_data,
    input  logic                        rd_flag,
    output logic                        wr_req,
    input  logic                        wr_grant,
    output logic [$clog2(DEPTH)-1:0]    wr_addr,
    output logic signed [WIDTH-1:0]     wr_data,
    output logic                        spike_valid,
    output logic [$clog2(DEPTH)-1:0]    spike_addr,
    output logic                        busy,
    output logic [7:0]                  stall_cnt
);

    localparam int AW = $clog2(DEPTH);

    state_e                  state_q;
    logic [AW-1:0]           addr_q;
    logic signed [WIDTH-1:0] weight_q;
    logic signed [WIDTH-1:0] pot_q;
    logic signed [WIDTH-1:0] wr_data_q;
    logic                    rd_req_q;
    logic                    wr_req_q;
    logic                    ev_ready_q;
    logic                    busy_q;
    logic [7:0]              stall_cnt_q;
    logic [7:0]              stall_cnt_d;

    logic                    calcFire;
    logic signed [WIDTH-1:0] calcWrData;

    lif_calc #(
        .WIDTH   (WIDTH),
        .THRESH  (THRESH),
        .V_RESET (V_RESET)
    ) u_lif_calc (
        .pot_i     (pot_q),
        .weight_i  (weight_q),
        .fire_o    (calcFire),
        .wr_data_o (calcWrData)
    );

    always_comb begin
        stall_cnt_d = (stall_cnt_q == STALL_MAX) ? stall_cnt_q : stall_cnt_q + 8'd1;
    end

    // A flag-0 grant keeps the FSM in RD_REQ but drops rd_req_q for one cycle;
    // grants seen while rd_req_q is low are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            weight_q    <= '0;
            pot_q       <= '0;
            wr_data_q   <= '0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            ev_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ev_valid && ev_ready_q) begin
                        addr_q     <= ev_addr;
                        weight_q   <= ev_weight;
                        ev_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        rd_req_q   <= 1'b1;
                        state_q    <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (!rd_req_q) begin
                        rd_req_q <= 1'b1;
                    end else if (rd_grant) begin
                        rd_req_q <= 1'b0;
                        if (rd_flag) begin
                            state_q <= RD_WAIT;
                        end else begin
                            stall_cnt_q <= stall_cnt_d;
                        end
                    end
                end
                RD_WAIT: begin
                    pot_q   <= rd_data;
                    state_q <= CALC;
                end
                CALC: begin
                    wr_data_q <= calcWrData;
                    wr_req_q  <= 1'b1;
                    state_q   <= WR_REQ;
                end
                WR_REQ: begin
                    if (wr_grant) begin
                        wr_req_q   <= 1'b0;
                        ev_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ev_ready    = ev_ready_q;
    assign busy        = busy_q;
    assign rd_req      = rd_req_q;
    assign rd_addr     = addr_q;
    assign wr_req      = wr_req_q;
    assign wr_addr     = addr_q;
    assign wr_data     = wr_data_q;
    assign spike_valid = (state_q == CALC) && calcFire;
    assign spike_addr  = addr_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_potential_updater.sv
// Directed bench for potential_updater: the bench plays the arbiter and the
// potential memory, with hand-computed write-back and spike expectations.
module tb_potential_updater;

    logic        clk = 1'b0;
    logic        rst;
    logic        ev_valid;
    logic        ev_ready;
    logic [3:0]  ev_addr;
    logic [31:0] ev_weight;
    logic        rd_req;
    logic        rd_grant;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_flag;
    logic        wr_req;
    logic        wr_grant;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        spike_valid;
    logic [3:0]  spike_addr;
    logic        busy;
    logic [7:0]  stall_cnt;

    int checksTotal  = 0;
    int checksPassed = 0;
    int checksFailed = 0;
    int expStall     = 0;

    potential_updater #(
        .WIDTH   (32),
        .DEPTH   (16),
        .THRESH  (1000),
        .V_RESET (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_addr     (ev_addr),
        .ev_weight   (ev_weight),
        .rd_req      (rd_req),
        .rd_grant    (rd_grant),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_flag     (rd_flag),
        .wr_req      (wr_req),
        .wr_grant    (wr_grant),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .spike_valid (spike_valid),
        .spike_addr  (spike_addr),
        .busy        (busy),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checksTotal++;
        assert (obs === exp) checksPassed++;
        else begin
            checksFailed++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full event: accept, nStall flag-0 retries, read, calc, write with
    // wrDelay idle cycles before the write grant.
    task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] weight,
                                 input logic [31:0] mem, input logic [31:0] expWr,
                                 input logic expSpike, input int nStall, input int wrDelay);
        @(negedge clk);
        checkOutput("idle_ev_ready", ev_ready, 1);
        ev_valid  = 1'b1;
        ev_addr   = addr;
        ev_weight = weight;
        @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
        checkOutput("rdreq_ev_ready", ev_ready, 0);
        checkOutput("rdreq_busy", busy, 1);
        checkOutput("rdreq_rd_req", rd_req, 1);
        checkOutput("rdreq_rd_addr", rd_addr, addr);
        for (int s = 0; s < nStall; s++) begin
            rd_grant = 1'b1;
            rd_flag  = 1'b0;
            @(posedge clk);
            @(negedge clk);
            expStall++;
            checkOutput("stall_rd_req_drop", rd_req, 0);
            checkOutput("stall_cnt", stall_cnt, expStall);
            @(posedge clk);
            @(negedge clk);
            checkOutput("stall_rd_req_again", rd_req, 1);
            checkOutput("stall_rd_addr", rd_addr, addr);
        end
        rd_grant = 1'b1;
        rd_flag  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_grant = 1'b0;
        rd_flag  = 1'b0;
        rd_data  = mem;
        checkOutput("rdwait_rd_req", rd_req, 0);
        checkOutput("rdwait_busy", busy, 1);
        @(posedge clk);
        @(negedge clk);
        rd_data = 32'hDEADBEEF;
        checkOutput("calc_spike_valid", spike_valid, expSpike);
        if (expSpike) begin
            checkOutput("calc_spike_addr", spike_addr, addr);
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput("wr_spike_cleared", spike_valid, 0);
        checkOutput("wr_wr_req", wr_req, 1);
        checkOutput("wr_wr_addr", wr_addr, addr);
        checkOutput("wr_wr_data", wr_data, expWr);
        checkOutput("wr_ev_ready", ev_ready, 0);
        for (int d = 0; d < wrDelay; d++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("hold_wr_req", wr_req, 1);
            checkOutput("hold_wr_addr", wr_addr, addr);
            checkOutput("hold_wr_data", wr_data, expWr);
            checkOutput("hold_ev_ready", ev_ready, 0);
        end
        wr_grant = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr_grant = 1'b0;
        checkOutput("done_wr_req", wr_req, 0);
        checkOutput("done_ev_ready", ev_ready, 1);
        checkOutput("done_busy", busy, 0);
        checkOutput("done_stall_cnt", stall_cnt, expStall);
    endtask

    initial begin
        rst       = 1'b0;
        ev_valid  = 1'b0;
        ev_addr   = '0;
        ev_weight = '0;
        rd_grant  = 1'b0;
        rd_data   = '0;
        rd_flag   = 1'b0;
        wr_grant  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ev_ready", ev_ready, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_rd_req", rd_req, 0);
        checkOutput("reset_wr_req", wr_req, 0);
        checkOutput("reset_spike", spike_valid, 0);
        checkOutput("reset_stall_cnt", stall_cnt, 0);
        checkOutput("reset_wr_data", wr_data, 0);
        rst = 1'b1;

        $display("[TB] basic update, no spike");
        applyStimulus(4'd3, 32'd100, 32'd500, 32'd600, 1'b0, 0, 0);
        $display("[TB] update crossing threshold");
        applyStimulus(4'd5, 32'd600, 32'd500, 32'd0, 1'b1, 0, 0);
        $display("[TB] positive saturation");
        applyStimulus(4'd7, 32'h00000100, 32'h7FFFFFF0, 32'd0, 1'b1, 0, 0);
        $display("[TB] negative saturation");
        applyStimulus(4'd8, 32'hFFFFFF00, 32'h80000010, 32'h80000000, 1'b0, 0, 0);
        $display("[TB] sum exactly at threshold");
        applyStimulus(4'd10, 32'd100, 32'd900, 32'd0, 1'b1, 0, 0);
        $display("[TB] sum one below threshold");
        applyStimulus(4'd11, 32'd100, 32'd899, 32'd999, 1'b0, 0, 0);
        $display("[TB] two flag-0 retries");
        applyStimulus(4'd2, 32'd10, 32'd20, 32'd30, 1'b0, 2, 0);
        $display("[TB] write grant delayed 10 cycles");
        applyStimulus(4'd9, 32'hFFFFFFCE, 32'd40, 32'hFFFFFFF6, 1'b0, 0, 10);

        $display("[TB] reset asserted in WR_REQ");
        @(negedge clk);
        ev_valid  = 1'b1;
        ev_addr   = 4'd4;
        ev_weight = 32'd1;
        @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
        rd_grant = 1'b1;
        rd_flag  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_grant = 1'b0;
        rd_flag  = 1'b0;
        rd_data  = 32'd2;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstwr_wr_req_before", wr_req, 1);
        #2;
        rst = 1'b0;
        expStall = 0;
        #1;
        checkOutput("rstwr_wr_req_async", wr_req, 0);
        checkOutput("rstwr_rd_req_async", rd_req, 0);
        checkOutput("rstwr_busy_async", busy, 0);
        checkOutput("rstwr_stall_cnt", stall_cnt, 0);
        checkOutput("rstwr_wr_data", wr_data, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstwr_ev_ready_after", ev_ready, 1);
        checkOutput("rstwr_wr_req_after", wr_req, 0);
        checkOutput("rstwr_busy_after", busy, 0);

        $display("[TB] normal event after reset");
        applyStimulus(4'd1, 32'd5, 32'd7, 32'd12, 1'b0, 0, 0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
